fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC, drives the instruction-memory request and holds the IF/ID pipeline register.
- Consumes the load-use `stall` from the hazard-detection unit, and the branch/jump `redirect` from EX.
- Supports a variable-latency instruction memory via `imem_ready`.
- Supports a sticky halt requested by decode (syscall/break).

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset.
- PC_INC, 4, byte increment per sequential fetch.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- stall  input  1  load-use stall from hazard unit; freeze PC and IF/ID
- redirect_valid  input  1  taken branch/jump resolved in EX
- redirect_pc  input  32  redirect target; bits [1:0] ignored, stored as 00
- halt_req  input  1  instruction in ID is a halt; sampled only when stall=0
- imem_req  output  1  fetch request this cycle
- imem_addr  output  32  fetch address (= pc, combinational)
- imem_rdata  input  32  instruction word; valid when imem_ready=1
- imem_ready  input  1  memory returns imem_rdata this cycle
- id_instr  output  32  IF/ID instruction
- id_pc_plus4  output  32  IF/ID pc+PC_INC
- id_valid  output  1  IF/ID holds a real instruction
- halted  output  1  fetch stopped by halt

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=BOOT.
  - id_instr=0 (NOP), id_pc_plus4=0, id_valid=0, halted=0.
  - imem_req=0.
- Reset mid-operation discards all state immediately; no partial update survives.
- FSM states: BOOT, RUN, HALT.
  - BOOT: one cycle, imem_req=0, IF/ID loads bubble; always goes to RUN next.
  - RUN: imem_req=1.
  - HALT: imem_req=0, halted=1.
- Per-cycle priority in RUN, highest first:
  1. redirect_valid:
     - pc <= {redirect_pc[31:2],2'b00}.
     - IF/ID <= bubble (id_valid=0, id_instr=0, id_pc_plus4=0).
     - Overrides stall and halt_req.
     - Fetched word discarded.
  2. stall:
     - pc, id_instr, id_pc_plus4 and id_valid all hold.
     - Fetched word discarded, even if imem_ready=1.
  3. halt_req (stall=0): pc holds, IF/ID <= bubble, state -> HALT.
  4. imem_ready=0: pc holds, IF/ID <= bubble; the request stays asserted at the same address.
  5. Normal:
     - pc <= pc+PC_INC.
     - id_instr <= imem_rdata, id_pc_plus4 <= pc+PC_INC, id_valid <= 1.
- HALT:
  - IF/ID <= bubble every cycle; stall is ignored.
  - redirect_valid: pc <= target, state -> RUN, halted=0 next cycle (the halt was on the wrong path).
  - Otherwise HALT holds until reset.
- Arithmetic: 32-bit, pc+PC_INC wraps modulo 2^32 (32'hFFFF_FFFC -> 0); no fault raised.
- Latency: an instruction returned with imem_ready=1 at cycle N appears on id_* after edge N (usable by ID in cycle N+1).
- Stall holding a bubble keeps the bubble; stall never creates id_valid=1.
- imem_addr is always pc, including in BOOT and HALT.
- imem_rdata is don't-care when imem_req=0.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds outputs perf_fetch_cnt[31:0] and perf_stall_cnt[31:0].
  - Both reset to 0 and wrap at 2^32.
  - perf_fetch_cnt increments on every normal-case IF/ID load (id_valid loaded as 1).
  - perf_stall_cnt increments in every RUN cycle with stall=1 and redirect_valid=0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, imem_ready=1, rdata=A,B,C:
  - cycle 1 BOOT, imem_req=0.
  - then id_instr=A/B/C with id_pc_plus4=0x00400004/08/0C, id_valid=1.
- stall=1 for 2 cycles after A loaded: pc stays 0x00400004, id_instr=A for both cycles; B is loaded on the first cycle after stall drops.
- redirect_valid=1 with redirect_pc=0x00401003 and stall=1 in the same cycle: next pc=0x00401000, id_valid=0; the next fetch gives id_pc_plus4=0x00401004.
- imem_ready=0 for 3 cycles: imem_addr constant, id_valid=0 for those cycles, pc unchanged; resumes on ready.
- halt_req=1 with stall=0: halted=1 next cycle, imem_req=0, id_valid=0 held for 10 cycles. Then redirect to 0x00400100: RUN, halted=0, fetch resumes at 0x00400100.
- Force pc=0xFFFFFFFC via redirect, then normal fetch: id_pc_plus4=0, next imem_addr=0. With FETCH_PERF_EN: perf_fetch_cnt and perf_stall_cnt match the scenario's counts.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage for the 5-stage MIPS pipeline.
// Owns the PC, issues instruction-memory requests and holds the IF/ID register.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   stall                load-use stall: freeze PC and IF/ID
//   redirect_valid/_pc   taken branch/jump from EX (target low two bits forced to 0)
//   halt_req             ID holds a syscall/break; enters sticky HALT
//   imem_req/_addr       fetch request and address (address is the PC)
//   imem_rdata/_ready    instruction word and its valid strobe
//   id_instr/_pc_plus4/_valid  IF/ID pipeline register
//   halted               fetch stopped by halt
// Optional build macro FETCH_PERF_EN adds perf_fetch_cnt / perf_stall_cnt.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int unsigned PC_INC   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid,
`ifdef FETCH_PERF_EN
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt,
`endif
  output logic        halted
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   pc4_q, pc4_d;
  logic              valid_q, valid_d;
  logic              fetch_load;
  logic [XLEN-1:0]   pc_next_seq;
  logic [XLEN-1:0]   redirect_tgt;

  // Target is word aligned; the dropped low bits are intentionally unused.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign redirect_tgt = {redirect_pc[31:2], 2'b00};
  assign pc_next_seq  = pc_q + XLEN'(PC_INC);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_BOOT;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (!redirect_valid && !stall && halt_req) state_d = ST_HALT;
      end
      ST_HALT: begin
        if (redirect_valid) state_d = ST_RUN;
      end
      default: state_d = ST_BOOT;
    endcase
  end

  // Output and datapath next-value logic; IF/ID defaults to a bubble
  always_comb begin
    imem_req   = 1'b0;
    halted     = 1'b0;
    pc_d       = pc_q;
    instr_d    = '0;
    pc4_d      = '0;
    valid_d    = 1'b0;
    fetch_load = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        imem_req = 1'b1;
        if (redirect_valid) begin
          pc_d = redirect_tgt;
        end else if (stall) begin
          instr_d = instr_q;
          pc4_d   = pc4_q;
          valid_d = valid_q;
        end else if (halt_req || !imem_ready) begin
          pc_d = pc_q;
        end else begin
          pc_d       = pc_next_seq;
          instr_d    = imem_rdata;
          pc4_d      = pc_next_seq;
          valid_d    = 1'b1;
          fetch_load = 1'b1;
        end
      end
      ST_HALT: begin
        halted = 1'b1;
        if (redirect_valid) pc_d = redirect_tgt;
      end
      default: ;
    endcase
  end

  // PC and IF/ID registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign imem_addr   = pc_q;
  assign id_instr    = instr_q;
  assign id_pc_plus4 = pc4_q;
  assign id_valid    = valid_q;

`ifdef FETCH_PERF_EN
  logic [XLEN-1:0] fetch_cnt_q, stall_cnt_q;
  logic            stall_cyc;

  assign stall_cyc = (state_q == ST_RUN) && stall && !redirect_valid;

  // Performance counters, free-running with natural wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (fetch_load) fetch_cnt_q <= fetch_cnt_q + XLEN'(1);
      if (stall_cyc)  stall_cnt_q <= stall_cnt_q + XLEN'(1);
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`else
  logic unused_fetch_load;
  assign unused_fetch_load = fetch_load;
`endif

endmodule
